// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-flush / dmem-freeze hazard control with a LOAD_LAT-deep shadow scoreboard.
// Latency: control outputs are combinational (zero cycles); scoreboard and counters update on clk.
// Backpressure: dmem_wait freezes the whole pipeline and the scoreboard; HAZARD_PERF_EN adds counters.
module hazard_ctrl_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             memread_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_wait,
  output logic             pc_write,
  output logic             write_ifid,
  output logic             mux_idex,
  output logic             flush_ifid,
  output logic             stall_lu,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic exHit1, exHit2;
  logic slotHit1, slotHit2;
  logic hazard;

  assign exHit1 = memread_ex && (rd_ex == rs1_id);
  assign exHit2 = memread_ex && (rd_ex == rs2_id);

  generate
    if (LOAD_LAT > 1) begin : gSb
      localparam int SLOTS = LOAD_LAT - 1;
      logic [SLOTS-1:0] slotVld;
      logic [REG_W-1:0] slotRd [SLOTS];

      // Slot 0 is the load that just left EX; the oldest entry falls off the end.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slotVld <= '0;
          for (int k = 0; k < SLOTS; k++) slotRd[k] <= '0;
        end else if (!dmem_wait) begin
          slotVld[0] <= memread_ex && (rd_ex != '0);
          slotRd[0]  <= rd_ex;
          for (int k = 1; k < SLOTS; k++) begin
            slotVld[k] <= slotVld[k-1];
            slotRd[k]  <= slotRd[k-1];
          end
        end
      end

      always_comb begin
        slotHit1 = 1'b0;
        slotHit2 = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
          if (slotVld[k] && (slotRd[k] == rs1_id)) slotHit1 = 1'b1;
          if (slotVld[k] && (slotRd[k] == rs2_id)) slotHit2 = 1'b1;
        end
      end
    end else begin : gNoSb
      logic unusedClk;
      assign unusedClk = clk;
      assign slotHit1  = 1'b0;
      assign slotHit2  = 1'b0;
    end
  endgenerate

  // x0 is hardwired zero, so it can never be waited on.
  assign hazard = (rs1_used && (rs1_id != '0) && (exHit1 || slotHit1)) ||
                  (rs2_used && (rs2_id != '0) && (exHit2 || slotHit2));

  always_comb begin
    pc_write   = 1'b1;
    write_ifid = 1'b1;
    mux_idex   = 1'b1;
    flush_ifid = 1'b0;
    stall_lu   = 1'b0;
    if (!rst_n) begin
      pc_write   = 1'b0;
      write_ifid = 1'b0;
      mux_idex   = 1'b0;
    end else if (dmem_wait) begin
      // Freeze keeps the ID controls flowing into a held ID/EX; any flush waits.
      pc_write   = 1'b0;
      write_ifid = 1'b0;
    end else if (branch_taken_ex) begin
      mux_idex   = 1'b0;
      flush_ifid = 1'b1;
    end else if (hazard) begin
      pc_write   = 1'b0;
      write_ifid = 1'b0;
      mux_idex   = 1'b0;
      stall_lu   = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallCnt, flushCnt;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating so a long run never reports a misleadingly small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall_lu && (stallCnt != '1))   stallCnt <= stallCnt + ONE;
      if (flush_ifid && (flushCnt != '1)) flushCnt <= flushCnt + ONE;
    end
  end

  assign stall_cnt = stallCnt;
  assign flush_cnt = flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
